sbp_pipeline_injector: RTL and testbench

// Head-of-pipeline source for the scalable pipelined lookup: drives the update/lookup slot protocol that

---
 rtl/sbp_pipeline_injector.sv | 242 ++++++++++++++++++++++++
 tb/tb_sbp_pipeline_injector.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbp_pipeline_injector.sv
// ----------------------------------------------------------------------------
// sbp_pipeline_injector
//
// Purpose:
//   Head-of-pipeline source for the scalable pipelined lookup. On every clock
//   it emits exactly one slot (update, ip_addr, bit_pos, stage_id, location,
//   result) that the first lookup stage consumes. Host update commands are
//   buffered in a small FIFO and arbitrated against lookup requests. A waiting
//   update is never starved for more than MAX_LOOKUP_RUN consecutive lookups.
//   When there is nothing to send, a bubble (stage_id 0, all fields 0) is
//   emitted.
//
// Configuration macro:
//   SBP_INJ_PREFIX_MASK_EN - when defined, prefix bits below the (clamped)
//                            prefix length are zeroed as the command is
//                            pushed. When undefined, the prefix is stored and
//                            emitted verbatim.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   lkp_valid_i        lookup request valid
//   lkp_ready_o        lookup granted this cycle (combinational)
//   lkp_ip_addr_i      address to look up
//   upd_valid_i        update command valid
//   upd_ready_o        update FIFO not full
//   upd_stage_id_i     target stage of the update
//   upd_location_i     target word in that stage
//   upd_prefix_i       prefix written to the node
//   upd_prefix_len_i   prefix length (values above 32 are clamped to 32)
//   upd_result_i       child/result field written to the node
//   upd_level_o        FIFO occupancy
//   update_o .. result_o  registered pipeline head slot
// ----------------------------------------------------------------------------
module sbp_pipeline_injector #(
   parameter int STAGE_ID_BITS  = 6,
   parameter int LOCATION_BITS  = 11,
   parameter int RESULT_BITS    = 24,
   parameter int ROOT_STAGE_ID  = 1,
   parameter int UPD_FIFO_DEPTH = 8,
   parameter int MAX_LOOKUP_RUN = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              lkp_valid_i,
   output logic                              lkp_ready_o,
   input  logic [31:0]                       lkp_ip_addr_i,
   input  logic                              upd_valid_i,
   output logic                              upd_ready_o,
   input  logic [STAGE_ID_BITS-1:0]          upd_stage_id_i,
   input  logic [LOCATION_BITS-1:0]          upd_location_i,
   input  logic [31:0]                       upd_prefix_i,
   input  logic [5:0]                        upd_prefix_len_i,
   input  logic [RESULT_BITS-1:0]            upd_result_i,
   output logic [$clog2(UPD_FIFO_DEPTH):0]   upd_level_o,
   output logic                              update_o,
   output logic [31:0]                       ip_addr_o,
   output logic [5:0]                        bit_pos_o,
   output logic [STAGE_ID_BITS-1:0]          stage_id_o,
   output logic [LOCATION_BITS-1:0]          location_o,
   output logic [RESULT_BITS-1:0]            result_o
);

   localparam int PTR_W = $clog2(UPD_FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   // run_cnt must hold 0..MAX_LOOKUP_RUN; keep at least one bit for MAX 0
   localparam int RUN_W = (MAX_LOOKUP_RUN < 1) ? 1 : $clog2(MAX_LOOKUP_RUN + 1);

   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_LOOKUP_RUN);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(UPD_FIFO_DEPTH);
   localparam logic [STAGE_ID_BITS-1:0] ROOT_ID = STAGE_ID_BITS'(ROOT_STAGE_ID);

   // Per-cycle grant decision
   localparam logic [1:0] GRANT_BUBBLE = 2'd0;
   localparam logic [1:0] GRANT_LOOKUP = 2'd1;
   localparam logic [1:0] GRANT_UPDATE = 2'd2;

   // FIFO storage, one array per field
   logic [STAGE_ID_BITS-1:0] fifo_stage_r    [UPD_FIFO_DEPTH];
   logic [LOCATION_BITS-1:0] fifo_location_r [UPD_FIFO_DEPTH];
   logic [31:0]              fifo_prefix_r   [UPD_FIFO_DEPTH];
   logic [5:0]               fifo_len_r      [UPD_FIFO_DEPTH];
   logic [RESULT_BITS-1:0]   fifo_result_r   [UPD_FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [LVL_W-1:0] level_r;
   logic [RUN_W-1:0] run_cnt_r;

   logic             fifo_ne_s;
   logic             fifo_full_s;
   logic             push_s;
   logic             pop_s;
   logic             run_at_max_s;
   logic [1:0]       grant_s;
   logic [5:0]       push_len_s;
   logic [31:0]      push_prefix_s;

   // Clamp out-of-range prefix lengths to a full-width match
   function automatic logic [5:0] clamp_len(input logic [5:0] len);
      logic [5:0] res;
      if (len > 6'd32) begin
         res = 6'd32;
      end else begin
         res = len;
      end
      return res;
   endfunction

   // FIFO status flags and handshake qualifiers
   always_comb begin
      fifo_ne_s    = (level_r != {LVL_W{1'b0}});
      fifo_full_s  = (level_r == LVL_FULL);
      run_at_max_s = (run_cnt_r == RUN_MAX);
      // A full FIFO refuses pushes even when a pop happens in the same cycle
      push_s       = upd_valid_i && !fifo_full_s;
      upd_ready_o  = !fifo_full_s;
   end

   // Prefix as it will be stored: clamped length, optional host-bit masking
   always_comb begin
      push_len_s = clamp_len(upd_prefix_len_i);
`ifdef SBP_INJ_PREFIX_MASK_EN
      // Shift by 32 yields 0, so len 32 keeps the prefix and len 0 clears it
      push_prefix_s = upd_prefix_i & ~(32'hFFFF_FFFF >> push_len_s);
`else
      push_prefix_s = upd_prefix_i;
`endif
   end

   // Arbitration: waiting update wins when no lookup is pending or the
   // lookup run has reached its limit; otherwise lookups go first.
   always_comb begin
      grant_s = GRANT_BUBBLE;
      if (rst) begin
         grant_s = GRANT_BUBBLE;
      end else if (fifo_ne_s && (!lkp_valid_i || run_at_max_s)) begin
         grant_s = GRANT_UPDATE;
      end else if (lkp_valid_i) begin
         grant_s = GRANT_LOOKUP;
      end else begin
         grant_s = GRANT_BUBBLE;
      end
      pop_s       = (grant_s == GRANT_UPDATE);
      lkp_ready_o = (grant_s == GRANT_LOOKUP);
   end

   assign upd_level_o = level_r;

   // FIFO data write; storage needs no reset because level_r gates its use
   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         fifo_stage_r[wr_ptr_r]    <= upd_stage_id_i;
         fifo_location_r[wr_ptr_r] <= upd_location_i;
         fifo_prefix_r[wr_ptr_r]   <= push_prefix_s;
         fifo_len_r[wr_ptr_r]      <= push_len_s;
         fifo_result_r[wr_ptr_r]   <= upd_result_i;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
      end else begin
         // Depth is a power of two, so pointers wrap naturally
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + {{(LVL_W-1){1'b0}}, 1'b1};
            2'b01:   level_r <= level_r - {{(LVL_W-1){1'b0}}, 1'b1};
            default: level_r <= level_r;
         endcase
      end
   end

   // Count consecutive lookups granted while an update is waiting
   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt_r <= {RUN_W{1'b0}};
      end else begin
         case (grant_s)
            GRANT_LOOKUP: begin
               if (!fifo_ne_s) begin
                  run_cnt_r <= {RUN_W{1'b0}};
               end else if (run_at_max_s) begin
                  run_cnt_r <= run_cnt_r;
               end else begin
                  run_cnt_r <= run_cnt_r + {{(RUN_W-1){1'b0}}, 1'b1};
               end
            end
            default: run_cnt_r <= {RUN_W{1'b0}};
         endcase
      end
   end

   // Registered head-of-pipeline slot
   always_ff @(posedge clk) begin
      if (rst) begin
         update_o   <= 1'b0;
         ip_addr_o  <= 32'h0000_0000;
         bit_pos_o  <= 6'd0;
         stage_id_o <= {STAGE_ID_BITS{1'b0}};
         location_o <= {LOCATION_BITS{1'b0}};
         result_o   <= {RESULT_BITS{1'b0}};
      end else begin
         case (grant_s)
            GRANT_UPDATE: begin
               // A stage-0 command is forwarded unchanged; no stage matches it
               update_o   <= 1'b1;
               ip_addr_o  <= fifo_prefix_r[rd_ptr_r];
               bit_pos_o  <= fifo_len_r[rd_ptr_r];
               stage_id_o <= fifo_stage_r[rd_ptr_r];
               location_o <= fifo_location_r[rd_ptr_r];
               result_o   <= fifo_result_r[rd_ptr_r];
            end
            GRANT_LOOKUP: begin
               update_o   <= 1'b0;
               ip_addr_o  <= lkp_ip_addr_i;
               bit_pos_o  <= 6'd0;
               stage_id_o <= ROOT_ID;
               location_o <= {LOCATION_BITS{1'b0}};
               result_o   <= {RESULT_BITS{1'b0}};
            end
            default: begin
               update_o   <= 1'b0;
               ip_addr_o  <= 32'h0000_0000;
               bit_pos_o  <= 6'd0;
               stage_id_o <= {STAGE_ID_BITS{1'b0}};
               location_o <= {LOCATION_BITS{1'b0}};
               result_o   <= {RESULT_BITS{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sbp_pipeline_injector.sv
// ----------------------------------------------------------------------------
// tb_sbp_pipeline_injector
//
// Directed bench for sbp_pipeline_injector (default parameters). A queue-based
// model predicts the slot and handshake outputs every cycle; a few cycles are
// additionally pinned to hand-computed literal values. Honours
// SBP_INJ_PREFIX_MASK_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_sbp_pipeline_injector;

   localparam int D      = 8;
   localparam int MAXRUN = 4;
   localparam int ROOT   = 1;

   typedef struct packed {
      logic        upd;
      logic [31:0] ip;
      logic [5:0]  bp;
      logic [5:0]  sid;
      logic [10:0] loc;
      logic [23:0] res;
   } slot_t;

   typedef struct packed {
      logic [5:0]  sid;
      logic [10:0] loc;
      logic [31:0] pfx;
      logic [5:0]  len;
      logic [23:0] res;
   } upd_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        lkp_valid;
   logic        lkp_ready;
   logic [31:0] lkp_ip;
   logic        upd_valid;
   logic        upd_ready;
   logic [5:0]  upd_sid;
   logic [10:0] upd_loc;
   logic [31:0] upd_pfx;
   logic [5:0]  upd_len;
   logic [23:0] upd_res;
   logic [3:0]  upd_level;
   logic        update_o;
   logic [31:0] ip_addr;
   logic [5:0]  bit_pos;
   logic [5:0]  stage_id;
   logic [10:0] location;
   logic [23:0] result;

   int total = 0;
   int bad   = 0;

   // Hand-computed pins for the current cycle
   logic  pin_slot_en = 1'b0;
   slot_t pin_slot    = '0;
   logic  pin_rdy_en  = 1'b0;
   logic  pin_lkp_rdy = 1'b0;
   logic  pin_upd_rdy = 1'b0;
   int    pin_level   = 0;

   upd_t  q[$];
   int    run_m = 0;

   always #5 clk = ~clk;

   sbp_pipeline_injector dut (
      .clk              (clk),
      .rst              (rst),
      .lkp_valid_i      (lkp_valid),
      .lkp_ready_o      (lkp_ready),
      .lkp_ip_addr_i    (lkp_ip),
      .upd_valid_i      (upd_valid),
      .upd_ready_o      (upd_ready),
      .upd_stage_id_i   (upd_sid),
      .upd_location_i   (upd_loc),
      .upd_prefix_i     (upd_pfx),
      .upd_prefix_len_i (upd_len),
      .upd_result_i     (upd_res),
      .upd_level_o      (upd_level),
      .update_o         (update_o),
      .ip_addr_o        (ip_addr),
      .bit_pos_o        (bit_pos),
      .stage_id_o       (stage_id),
      .location_o       (location),
      .result_o         (result)
   );

   // What the FIFO entry must hold after the push rules are applied
   function automatic upd_t mk_entry(input logic [5:0] sid, input logic [10:0] loc,
                                     input logic [31:0] pfx, input logic [5:0] len,
                                     input logic [23:0] res);
      upd_t        e;
      int          l;
      logic [31:0] p;
      l = (int'(len) > 32) ? 32 : int'(len);
      p = pfx;
`ifdef SBP_INJ_PREFIX_MASK_EN
      for (int b = 0; b < 32; b++) begin
         if (b < 32 - l) p[b] = 1'b0;
      end
`endif
      e.sid = sid; e.loc = loc; e.pfx = p; e.len = 6'(l); e.res = res;
      return e;
   endfunction

   task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Compare process: handshake outputs mid-cycle, slot outputs after the edge
   initial begin : compare_proc
      slot_t exp_s;
      slot_t got_s;
      slot_t p_slot;
      logic  p_en;
      logic  e_lr;
      logic  e_ur;
      int    e_lvl;
      logic  ne;
      logic  take_upd;
      logic  take_lkp;
      logic  do_push;
      upd_t  ent;
      upd_t  head;
      @(posedge clk);
      forever begin
         @(negedge clk);
         #3;
         ne       = (q.size() != 0);
         e_ur     = (q.size() < D);
         e_lvl    = q.size();
         take_upd = !rst && ne && (!lkp_valid || run_m == MAXRUN);
         take_lkp = !rst && !take_upd && lkp_valid;
         e_lr     = take_lkp;
         chk("lkp_ready", {79'd0, lkp_ready}, {79'd0, e_lr});
         chk("upd_ready", {79'd0, upd_ready}, {79'd0, e_ur});
         chk("upd_level", {76'd0, upd_level}, {76'd0, 4'(e_lvl)});
         if (pin_rdy_en) begin
            chk("pin_lkp_ready", {79'd0, lkp_ready}, {79'd0, pin_lkp_rdy});
            chk("pin_upd_ready", {79'd0, upd_ready}, {79'd0, pin_upd_rdy});
            chk("pin_level", {76'd0, upd_level}, {76'd0, 4'(pin_level)});
            chk("model_level_pin", {76'd0, 4'(e_lvl)}, {76'd0, 4'(pin_level)});
         end
         if (rst) begin
            q.delete();
            run_m = 0;
            exp_s = '0;
         end else begin
            do_push = upd_valid && (q.size() < D);
            ent     = mk_entry(upd_sid, upd_loc, upd_pfx, upd_len, upd_res);
            if (take_upd) begin
               head  = q.pop_front();
               exp_s = '{upd: 1'b1, ip: head.pfx, bp: head.len, sid: head.sid,
                         loc: head.loc, res: head.res};
               run_m = 0;
            end else if (take_lkp) begin
               exp_s = '{upd: 1'b0, ip: lkp_ip, bp: 6'd0, sid: 6'(ROOT),
                         loc: 11'd0, res: 24'd0};
               run_m = ne ? ((run_m + 1 > MAXRUN) ? MAXRUN : run_m + 1) : 0;
            end else begin
               exp_s = '0;
               run_m = 0;
            end
            if (do_push) q.push_back(ent);
         end
         p_en   = pin_slot_en;
         p_slot = pin_slot;
         @(posedge clk);
         #1;
         got_s = '{upd: update_o, ip: ip_addr, bp: bit_pos, sid: stage_id,
                   loc: location, res: result};
         chk("slot", got_s, exp_s);
         if (p_en) begin
            chk("pin_slot", got_s, p_slot);
            chk("model_slot_pin", exp_s, p_slot);
         end
      end
   end

   task automatic drive(input logic r, input logic lv, input logic [31:0] lip,
                        input logic uv, input logic [5:0] sid, input logic [10:0] loc,
                        input logic [31:0] pfx, input logic [5:0] len, input logic [23:0] res);
      @(negedge clk);
      rst = r; lkp_valid = lv; lkp_ip = lip;
      upd_valid = uv; upd_sid = sid; upd_loc = loc; upd_pfx = pfx; upd_len = len; upd_res = res;
      pin_slot_en = 1'b0;
      pin_rdy_en  = 1'b0;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'd0, 1'b0, 6'd0, 11'd0, 32'd0, 6'd0, 24'd0);
   endtask

   task automatic pin_s(input logic u, input logic [31:0] ip, input logic [5:0] bp,
                        input logic [5:0] sid, input logic [10:0] loc, input logic [23:0] res);
      pin_slot_en = 1'b1;
      pin_slot    = '{upd: u, ip: ip, bp: bp, sid: sid, loc: loc, res: res};
   endtask

   task automatic pin_r(input logic lr, input logic ur, input int lvl);
      pin_rdy_en  = 1'b1;
      pin_lkp_rdy = lr;
      pin_upd_rdy = ur;
      pin_level   = lvl;
   endtask

   initial begin : stimulus
      logic [31:0] exp_ip;
      rst = 1'b1; lkp_valid = 1'b1; lkp_ip = 32'h5555_AAAA;
      upd_valid = 1'b1; upd_sid = 6'd9; upd_loc = 11'd9; upd_pfx = 32'h9999_9999;
      upd_len = 6'd9; upd_res = 24'h999999;

      // Reset held 3 cycles with both requesters active
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 32'h5555_AAAA, 1'b1, 6'd9, 11'd9, 32'h9999_9999, 6'd9, 24'h999999);
         if (i == 2) begin
            pin_r(1'b0, 1'b1, 0);
            pin_s(1'b0, 32'd0, 6'd0, 6'd0, 11'd0, 24'd0);
         end
      end
      // First lookup after release
      drive(1'b0, 1'b1, 32'h1111_2222, 1'b0, 6'd0, 11'd0, 32'd0, 6'd0, 24'd0);
      pin_r(1'b1, 1'b1, 0);
      pin_s(1'b0, 32'h1111_2222, 6'd0, 6'd1, 11'd0, 24'd0);

      // Single lookup then idle bubble
      drive(1'b0, 1'b1, 32'hC0A8_0101, 1'b0, 6'd0, 11'd0, 32'd0, 6'd0, 24'd0);
      pin_s(1'b0, 32'hC0A8_0101, 6'd0, 6'd1, 11'd0, 24'd0);
      idle();
      pin_s(1'b0, 32'd0, 6'd0, 6'd0, 11'd0, 24'd0);

      // Lone update: bubble in push cycle, update slot the cycle after
      drive(1'b0, 1'b0, 32'd0, 1'b1, 6'd3, 11'h005, 32'h0A00_0000, 6'd8, 24'h123456);
      pin_r(1'b0, 1'b1, 0);
      pin_s(1'b0, 32'd0, 6'd0, 6'd0, 11'd0, 24'd0);
      idle();
      pin_r(1'b0, 1'b1, 1);
      pin_s(1'b1, 32'h0A00_0000, 6'd8, 6'd3, 11'h005, 24'h123456);
      idle();
      pin_r(1'b0, 1'b1, 0);

      // Continuous lookups with one queued update: 4 lookups then the update
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 1'b1, 32'hA000_0000 + 32'(i), (i == 0), 6'd7, 11'h7FF,
               32'hFFFF_FFFF, 6'd32, 24'hABCDEF);
         if (i == 4) pin_r(1'b1, 1'b1, 1);
         if (i == 5) begin
            pin_r(1'b0, 1'b1, 1);
            pin_s(1'b1, 32'hFFFF_FFFF, 6'd32, 6'd7, 11'h7FF, 24'hABCDEF);
         end
         if (i == 6) pin_s(1'b0, 32'hA000_0006, 6'd0, 6'd1, 11'd0, 24'd0);
      end
      idle();

      // Fill the FIFO under lookup pressure, then drain in order
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b1, 32'hB000_0000 + 32'(k), 1'b1, 6'(k + 1), 11'(k),
               32'h1000_0000 + 32'(k), 6'(k), 24'h000100 + 24'(k));
         if (k == 9) pin_r(1'b1, 1'b0, 8);
      end
      for (int k = 10; k < 19; k++) begin
         idle();
         if (k == 10) begin
            pin_r(1'b0, 1'b0, 8);
`ifdef SBP_INJ_PREFIX_MASK_EN
            exp_ip = 32'h0000_0000;
`else
            exp_ip = 32'h1000_0001;
`endif
            pin_s(1'b1, exp_ip, 6'd1, 6'd2, 11'd1, 24'h000101);
         end
         if (k == 18) begin
            pin_r(1'b0, 1'b1, 0);
            pin_s(1'b0, 32'd0, 6'd0, 6'd0, 11'd0, 24'd0);
         end
      end

      // Prefix masking and length clamp
      drive(1'b0, 1'b0, 32'd0, 1'b1, 6'd2, 11'h010, 32'h0A0B_0C0D, 6'd16, 24'h000001);
      idle();
`ifdef SBP_INJ_PREFIX_MASK_EN
      exp_ip = 32'h0A0B_0000;
`else
      exp_ip = 32'h0A0B_0C0D;
`endif
      pin_s(1'b1, exp_ip, 6'd16, 6'd2, 11'h010, 24'h000001);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 6'd63, 11'd0, 32'hDEAD_BEEF, 6'd40, 24'hFFFFFF);
      idle();
      pin_s(1'b1, 32'hDEAD_BEEF, 6'd32, 6'd63, 11'd0, 24'hFFFFFF);
      // Stage-0 command forwarded as a no-op update
      drive(1'b0, 1'b0, 32'd0, 1'b1, 6'd0, 11'h003, 32'h1234_5678, 6'd0, 24'h000000);
      idle();
`ifdef SBP_INJ_PREFIX_MASK_EN
      exp_ip = 32'h0000_0000;
`else
      exp_ip = 32'h1234_5678;
`endif
      pin_s(1'b1, exp_ip, 6'd0, 6'd0, 11'h003, 24'h000000);

      // Reset mid-operation discards queued updates
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b1, 32'hD000_0000 + 32'(k), 1'b1, 6'd5, 11'(k),
               32'hCAFE_0000 + 32'(k), 6'd32, 24'(k));
         if (k == 5) pin_r(1'b0, 1'b1, 5);
      end
      drive(1'b1, 1'b1, 32'hD000_0006, 1'b1, 6'd5, 11'd6, 32'hCAFE_0006, 6'd32, 24'd6);
      pin_s(1'b0, 32'd0, 6'd0, 6'd0, 11'd0, 24'd0);
      idle();
      pin_r(1'b0, 1'b1, 0);
      pin_s(1'b0, 32'd0, 6'd0, 6'd0, 11'd0, 24'd0);

      idle();
      idle();
      @(posedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
